pipeline_hazard_ctrl: RTL
=========================

Name: pipeline_hazard_ctrl

Overview:
Central stall/flush controller for the 5-stage in-order pipeline.
- Drives the PC enable, the IF/ID and ID/EX stall/flush controls, and the EX/MEM bubble.
- Resolves four hazard sources: load-use, EX-resolved branch/jump redirect, multi-cycle mul/div occupancy in EX, and instruction-memory not-ready.
- Keeps saturating performance counters for stall cycles, redirects and load-use events.

Parameters:
- MULDIV_LATENCY, 32: total EX-stage occupancy in cycles of a mul/div instruction. Legal range is >=1; the value 1 means no stall.
- CNT_W, $clog2(MULDIV_LATENCY+1): width of the mul/div down-counter.
- PERF_W, 32: width of each performance counter.

Ports:
- clk  in  1  pipeline clock
- rst  in  1  asynchronous, active-high reset
- id_rs1  in  5  source register 1 of the instruction in ID
- id_rs2  in  5  source register 2 of the instruction in ID
- id_use_rs1  in  1  the ID instruction reads rs1
- id_use_rs2  in  1  the ID instruction reads rs2
- ex_rd  in  5  destination register of the instruction in EX
- ex_mem_read  in  1  the EX instruction is a load
- ex_muldiv  in  1  the EX instruction is a valid multi-cycle mul/div
- ex_redirect  in  1  a taken branch/jump is resolved in EX this cycle
- imem_ready  in  1  instruction memory returns valid data for the current PC
- pc_stall  out  1  hold the PC
- if_id_stall  out  1  hold IF/ID
- if_id_flush  out  1  zero IF/ID
- id_ex_stall  out  1  hold ID/EX
- id_ex_flush  out  1  zero ID/EX (insert a bubble)
- ex_mem_flush  out  1  insert a bubble into EX/MEM
- muldiv_busy  out  1  the FSM is in state MD_BUSY
- muldiv_done  out  1  one-cycle pulse: the mul/div result is valid in EX this cycle
- perf_stall  out  PERF_W  count of cycles with pc_stall=1
- perf_redirect  out  PERF_W  count of applied redirects
- perf_loaduse  out  PERF_W  count of cycles with an applied load-use stall

Behaviour:
Reset values (while rst=1, asynchronous):
- if_id_flush=1 and id_ex_flush=1.
- All other control outputs are 0.
- State=RUN, counter=0, all perf counters=0.

FSM states: RUN, MD_BUSY.
- RUN -> MD_BUSY when ex_muldiv=1 and MULDIV_LATENCY>=2. Load the counter with MULDIV_LATENCY-2.
- MD_BUSY with counter!=0: decrement the counter and stay in MD_BUSY.
- MD_BUSY with counter==0: muldiv_done=1, all stalls released, go to RUN.
- With MULDIV_LATENCY=1: never enter MD_BUSY; muldiv_done pulses in the same cycle ex_muldiv=1.

Hazard terms, all combinational, same-cycle:
- loaduse = ex_mem_read & (ex_rd!=0) & ((id_use_rs1 & id_rs1==ex_rd) | (id_use_rs2 & id_rs2==ex_rd)).
- md_hold = (RUN & ex_muldiv & LATENCY>=2) | (MD_BUSY & counter!=0).

Output priority (highest first; exactly one row applies):
1. md_hold: pc_stall=1, if_id_stall=1, id_ex_stall=1, ex_mem_flush=1. Redirect, load-use and fetch wait are masked.
2. ex_redirect: if_id_flush=1, id_ex_flush=1, pc_stall=0 (the PC loads the target). This row overrides load-use and imem_ready=0.
3. loaduse: pc_stall=1, if_id_stall=1, id_ex_flush=1.
4. !imem_ready: pc_stall=1, if_id_flush=1.
5. Otherwise: all control outputs are 0.

Invariants:
- A stage's stall and flush are never both 1 in the same cycle.
- ex_redirect=1 together with md_hold=1 is illegal; the bench asserts it never occurs.

Performance counters:
- Increment on the clock edge per the conditions in the port list.
- Saturate at all-ones; never wrap.

Reset mid-operation (e.g. during MD_BUSY):
- State and counters clear immediately.
- After deassertion the FSM restarts in RUN; no muldiv_done pulse for the aborted operation.

Decomposition:
- Package hazard_pkg holds:
  - state enum hz_state_e {RUN, MD_BUSY};
  - REG_ADDR_W=5;
  - a zero-register constant.
- One sub-module, hazard_perf_cnt (PERF_W-bit saturating counter with an inc enable), instantiated 3x.

Test Plan:
- Load-use: ex_mem_read=1, ex_rd=5, id_rs1=5, id_use_rs1=1 -> same cycle pc_stall=1, if_id_stall=1, id_ex_flush=1; perf_loaduse 0->1. Repeat with ex_rd=0 -> all controls 0.
- Priority: ex_redirect=1 with the load-use condition active and imem_ready=0 -> if_id_flush=1, id_ex_flush=1, pc_stall=0, if_id_stall=0; perf_redirect +1, perf_loaduse unchanged.
- Mul/div, LATENCY=4: ex_muldiv=1 from cycle 0 ->
  - stalls and ex_mem_flush=1 in cycles 0-2;
  - muldiv_busy=1 in cycles 1-3;
  - cycle 3: stalls=0, muldiv_done=1;
  - cycle 4: RUN.
  Then back-to-back (ex_muldiv still 1 at cycle 4) -> re-enters MD_BUSY; muldiv_done at cycle 7.
- Fetch wait: imem_ready=0 for 3 cycles -> pc_stall=1, if_id_flush=1 each cycle; perf_stall=3.
- Async reset: rst pulsed in cycle 2 of a LATENCY=8 mul/div -> before the next clock edge, pc_stall=0, if_id_flush=1, id_ex_flush=1, muldiv_busy=0; after release, RUN, no muldiv_done, perf counters=0.
- Saturation, PERF_W=4: 20 consecutive load-use cycles -> perf_stall=15 and perf_loaduse=15, held with no wrap.

Source files
------------

// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package hazard_pkg;

    localparam int REG_ADDR_W = 5;
    localparam logic [REG_ADDR_W-1:0] ZERO_REG = '0;

    typedef enum logic [0:0] {
        RUN     = 1'b0,
        MD_BUSY = 1'b1
    } hz_state_e;

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard-sense inputs, stall/flush controls and perf counters between the pipeline and the controller.
interface pipeline_hazard_ctrl_if
    import hazard_pkg::*;
#(
    parameter int PERF_W = 32
);
    logic [REG_ADDR_W-1:0] id_rs1;
    logic [REG_ADDR_W-1:0] id_rs2;
    logic                  id_use_rs1;
    logic                  id_use_rs2;
    logic [REG_ADDR_W-1:0] ex_rd;
    logic                  ex_mem_read;
    logic                  ex_muldiv;
    logic                  ex_redirect;
    logic                  imem_ready;

    logic                  pc_stall;
    logic                  if_id_stall;
    logic                  if_id_flush;
    logic                  id_ex_stall;
    logic                  id_ex_flush;
    logic                  ex_mem_flush;
    logic                  muldiv_busy;
    logic                  muldiv_done;
    logic [PERF_W-1:0]     perf_stall;
    logic [PERF_W-1:0]     perf_redirect;
    logic [PERF_W-1:0]     perf_loaduse;

    modport master (
        output id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rd, ex_mem_read,
               ex_muldiv, ex_redirect, imem_ready,
        input  pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush,
               ex_mem_flush, muldiv_busy, muldiv_done,
               perf_stall, perf_redirect, perf_loaduse
    );

    modport slave (
        input  id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rd, ex_mem_read,
               ex_muldiv, ex_redirect, imem_ready,
        output pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush,
               ex_mem_flush, muldiv_busy, muldiv_done,
               perf_stall, perf_redirect, perf_loaduse
    );

endinterface

// File: rtl/pipeline_hazard_ctrl_perf_cnt.sv
// Saturating event counter: counts up on inc and sticks at all-ones.
module hazard_perf_cnt #(
    parameter int PERF_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              inc,
    output logic [PERF_W-1:0] count
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + PERF_W'(1);
        end
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Central stall/flush controller: load-use, EX redirect, mul/div occupancy and fetch wait,
// plus saturating performance counters.
module pipeline_hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int MULDIV_LATENCY = 32,
    parameter int CNT_W          = $clog2(MULDIV_LATENCY + 1),
    parameter int PERF_W         = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    pipeline_hazard_ctrl_if.slave  hz
);

    localparam bit MD_MULTI = (MULDIV_LATENCY >= 2);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MD_MULTI ? MULDIV_LATENCY - 2 : 0);

    hz_state_e        state;
    logic [CNT_W-1:0] cnt;
    logic             busy_q;

    // Cycle 0 of a mul/div is spent in RUN, so the counter covers the remaining cycles minus the done cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= RUN;
            cnt    <= '0;
            busy_q <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    if (hz.ex_muldiv && MD_MULTI) begin
                        state  <= MD_BUSY;
                        cnt    <= CNT_LOAD;
                        busy_q <= 1'b1;
                    end
                end
                MD_BUSY: begin
                    if (cnt != '0) begin
                        cnt <= cnt - CNT_W'(1);
                    end else begin
                        state  <= RUN;
                        busy_q <= 1'b0;
                    end
                end
                default: begin
                    state  <= RUN;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    logic rs1_hit, rs2_hit, loaduse, md_hold, md_done;

    assign rs1_hit = hz.id_use_rs1 && (hz.id_rs1 == hz.ex_rd);
    assign rs2_hit = hz.id_use_rs2 && (hz.id_rs2 == hz.ex_rd);
    assign loaduse = hz.ex_mem_read && (hz.ex_rd != ZERO_REG) && (rs1_hit || rs2_hit);
    assign md_hold = ((state == RUN) && hz.ex_muldiv && MD_MULTI) ||
                     ((state == MD_BUSY) && (cnt != '0));
    assign md_done = ((state == RUN) && hz.ex_muldiv && !MD_MULTI) ||
                     ((state == MD_BUSY) && (cnt == '0));

    logic pc_stall_c, if_id_stall_c, if_id_flush_c, id_ex_stall_c, id_ex_flush_c, ex_mem_flush_c;
    logic redirect_c, loaduse_c;

    // Reset forces both pipeline registers to flush so nothing stale issues after release
    always_comb begin
        pc_stall_c     = 1'b0;
        if_id_stall_c  = 1'b0;
        if_id_flush_c  = 1'b0;
        id_ex_stall_c  = 1'b0;
        id_ex_flush_c  = 1'b0;
        ex_mem_flush_c = 1'b0;
        redirect_c     = 1'b0;
        loaduse_c      = 1'b0;
        if (rst) begin
            if_id_flush_c = 1'b1;
            id_ex_flush_c = 1'b1;
        end else if (md_hold) begin
            pc_stall_c     = 1'b1;
            if_id_stall_c  = 1'b1;
            id_ex_stall_c  = 1'b1;
            ex_mem_flush_c = 1'b1;
        end else if (hz.ex_redirect) begin
            if_id_flush_c = 1'b1;
            id_ex_flush_c = 1'b1;
            redirect_c    = 1'b1;
        end else if (loaduse) begin
            pc_stall_c    = 1'b1;
            if_id_stall_c = 1'b1;
            id_ex_flush_c = 1'b1;
            loaduse_c     = 1'b1;
        end else if (!hz.imem_ready) begin
            pc_stall_c    = 1'b1;
            if_id_flush_c = 1'b1;
        end
    end

    assign hz.pc_stall     = pc_stall_c;
    assign hz.if_id_stall  = if_id_stall_c;
    assign hz.if_id_flush  = if_id_flush_c;
    assign hz.id_ex_stall  = id_ex_stall_c;
    assign hz.id_ex_flush  = id_ex_flush_c;
    assign hz.ex_mem_flush = ex_mem_flush_c;
    assign hz.muldiv_busy  = busy_q;
    assign hz.muldiv_done  = md_done && !rst;

    hazard_perf_cnt #(.PERF_W(PERF_W)) u_perf_stall (
        .clk(clk), .rst(rst), .inc(pc_stall_c), .count(hz.perf_stall)
    );

    hazard_perf_cnt #(.PERF_W(PERF_W)) u_perf_redirect (
        .clk(clk), .rst(rst), .inc(redirect_c), .count(hz.perf_redirect)
    );

    hazard_perf_cnt #(.PERF_W(PERF_W)) u_perf_loaduse (
        .clk(clk), .rst(rst), .inc(loaduse_c), .count(hz.perf_loaduse)
    );

endmodule
